mole_round_controller: RTL and testbench

//  Requester side of the unique-slot selection handshake for whack-a-mole.

---
 rtl/mole_round_controller.sv | 175 +++++++++++++++++
 tb/tb_mole_round_controller.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mole_round_controller.sv
// Whack-a-mole round sequencer: requests a slot from the unique selector, lights that mole,
// scores the player's press and repeats until every slot is used. Optional: WRONG_PENALTY_EN.
module mole_round_controller #(
  parameter int unsigned SHOW_CYCLES = 1000,
  parameter int unsigned GAP_CYCLES  = 200,
  parameter int unsigned REQ_TIMEOUT = 64,
  parameter int unsigned SCORE_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sel_done,
  input  logic [2:0]         sel_number,
  input  logic               sel_all_selected,
  input  logic [7:0]         btn,
  output logic               req,
  output logic [7:0]         mole_onehot,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] miss_count,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic               busy,
  output logic               game_over,
  output logic               timeout_err
);

  localparam int unsigned MAX_SG   = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int unsigned MAX_LOAD = (MAX_SG > REQ_TIMEOUT) ? MAX_SG : REQ_TIMEOUT;
  localparam int unsigned CNT_W    = (MAX_LOAD < 2) ? 1 : $clog2(MAX_LOAD);

  // Down-counter loads: the counter expires on the last cycle of each timed phase.
  // The selector window spans REQ_TIMEOUT-1 WAIT_SEL cycles so ERR shows REQ_TIMEOUT cycles after req.
  localparam logic [CNT_W-1:0] SHOW_LOAD = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LOAD  = CNT_W'((REQ_TIMEOUT > 1) ? (REQ_TIMEOUT - 2) : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_SEL,
    S_SHOW,
    S_GAP,
    S_OVER,
    S_ERR
  } state_t;

  state_t             state;
  state_t             state_n;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_n;
  logic [7:0]         mole_n;
  logic [SCORE_W-1:0] score_n;
  logic [SCORE_W-1:0] miss_n;
  logic               hit_n;
  logic               miss_pulse_n;
  logic               hit_c;
  logic               wrong_c;
  logic               cnt_zero_c;

  assign hit_c      = |(btn & mole_onehot);
  assign cnt_zero_c = (cnt == '0);

`ifdef WRONG_PENALTY_EN
  assign wrong_c = |(btn & ~mole_onehot);
`else
  assign wrong_c = 1'b0;
`endif

  // Next-state, counter and scoring decisions
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    mole_n       = mole_onehot;
    score_n      = score;
    miss_n       = miss_count;
    hit_n        = 1'b0;
    miss_pulse_n = 1'b0;

    case (state)
      S_IDLE: begin
        mole_n = '0;
        if (start) begin
          state_n = S_REQ;
          score_n = '0;
          miss_n  = '0;
        end
      end

      S_REQ: begin
        cnt_n   = TMO_LOAD;
        state_n = S_WAIT_SEL;
      end

      S_WAIT_SEL: begin
        if (sel_done) begin
          mole_n  = 8'b1 << sel_number;
          cnt_n   = SHOW_LOAD;
          state_n = S_SHOW;
        end else if (cnt_zero_c) begin
          state_n = S_ERR;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end

      S_SHOW: begin
        // A correct press wins over both expiry and a simultaneous wrong press.
        if (hit_c) begin
          hit_n   = 1'b1;
          score_n = (score == '1) ? score : score + SCORE_W'(1);
          mole_n  = '0;
          cnt_n   = GAP_LOAD;
          state_n = S_GAP;
        end else if (wrong_c || cnt_zero_c) begin
          miss_pulse_n = 1'b1;
          miss_n       = (miss_count == '1) ? miss_count : miss_count + SCORE_W'(1);
          mole_n       = '0;
          cnt_n        = GAP_LOAD;
          state_n      = S_GAP;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end

      S_GAP: begin
        mole_n = '0;
        if (cnt_zero_c) begin
          state_n = sel_all_selected ? S_OVER : S_REQ;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end

      // Terminal states: only rst leaves, since the selector mask clears only on rst.
      S_OVER: mole_n = '0;
      S_ERR:  mole_n = '0;

      default: begin
        state_n = S_IDLE;
        mole_n  = '0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      req         <= 1'b0;
      mole_onehot <= '0;
      score       <= '0;
      miss_count  <= '0;
      hit_pulse   <= 1'b0;
      miss_pulse  <= 1'b0;
      busy        <= 1'b0;
      game_over   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      req         <= (state_n == S_REQ);
      mole_onehot <= mole_n;
      score       <= score_n;
      miss_count  <= miss_n;
      hit_pulse   <= hit_n;
      miss_pulse  <= miss_pulse_n;
      busy        <= (state_n == S_REQ) || (state_n == S_WAIT_SEL) ||
                     (state_n == S_SHOW) || (state_n == S_GAP);
      game_over   <= (state_n == S_OVER);
      timeout_err <= (state_n == S_ERR);
    end
  end

endmodule

// File: tb/tb_mole_round_controller.sv
// Bench for mole_round_controller: directed spec scenarios plus randomized games checked
// against a round-timeline model (event cycles computed arithmetically from the rules).
module tb_mole_round_controller;

  localparam int unsigned SHOW = 4;
  localparam int unsigned GAP  = 2;
  localparam int unsigned TMO  = 6;
  localparam int unsigned SW   = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          sel_done;
  logic [2:0]    sel_number;
  logic          sel_all_selected;
  logic [7:0]    btn;
  logic          req;
  logic [7:0]    mole_onehot;
  logic [SW-1:0] score;
  logic [SW-1:0] miss_count;
  logic          hit_pulse;
  logic          miss_pulse;
  logic          busy;
  logic          game_over;
  logic          timeout_err;

  int total = 0;
  int bad   = 0;
  logic [SW-1:0] exp_score;
  logic [SW-1:0] exp_miss;

  mole_round_controller #(
    .SHOW_CYCLES(SHOW), .GAP_CYCLES(GAP), .REQ_TIMEOUT(TMO), .SCORE_W(SW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .sel_done(sel_done), .sel_number(sel_number),
    .sel_all_selected(sel_all_selected), .btn(btn), .req(req), .mole_onehot(mole_onehot),
    .score(score), .miss_count(miss_count), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
    .busy(busy), .game_over(game_over), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Observation point: 1 time unit after the active edge; inputs set here apply to this cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; sel_done = 1'b0; sel_number = '0;
    sel_all_selected = 1'b0; btn = '0;
    tick();
    tick();
    rst = 1'b0;
    exp_score = '0;
    exp_miss  = '0;
  endtask

  task automatic start_game();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_score = '0;
    exp_miss  = '0;
    total++;
    if ({req, busy, score, miss_count} !== {1'b1, 1'b1, 4'h0, 4'h0}) begin
      bad++;
      $display("FAIL start_req: req=%b busy=%b score=%0d miss=%0d, want 1 1 0 0",
               req, busy, score, miss_count);
    end
  endtask

  // Entered in the REQ cycle. Selector answers d cycles after req; one press at SHOW cycle press_k.
  task automatic run_round(input int d, input logic [2:0] slot, input int press_k,
                           input logic [7:0] press_val, input bit last, input bit stray);
    logic [7:0] m;
    int         k_end;
    bit         hit;
    m = 8'b1 << slot;
    total++;
    if ({req, busy, mole_onehot} !== {1'b1, 1'b1, 8'h00}) begin
      bad++;
      $display("FAIL round_req: req=%b busy=%b mole=%h, want 1 1 00", req, busy, mole_onehot);
    end
    for (int i = 1; i <= d; i++) begin
      tick();
      sel_done = 1'b0;
      total++;
      if ({req, busy, mole_onehot, timeout_err} !== {1'b1 ^ 1'b1, 1'b1, 8'h00, 1'b0}) begin
        bad++;
        $display("FAIL wait_sel: req=%b busy=%b mole=%h terr=%b, want 0 1 00 0",
                 req, busy, mole_onehot, timeout_err);
      end
      if (i == d) begin
        sel_done   = 1'b1;
        sel_number = slot;
        if (last) sel_all_selected = 1'b1;
      end
    end
    // Predicted outcome of the window
    hit   = 1'b0;
    k_end = SHOW;
    if (press_k >= 1 && press_k <= int'(SHOW)) begin
      if ((press_val & m) != 8'h00) begin
        hit   = 1'b1;
        k_end = press_k;
      end
`ifdef WRONG_PENALTY_EN
      else if (press_val != 8'h00) k_end = press_k;
`endif
    end
    for (int k = 1; k <= k_end; k++) begin
      tick();
      sel_done = 1'b0;
      btn      = '0;
      total++;
      if ({mole_onehot, req, busy, hit_pulse, miss_pulse} !== {m, 1'b0, 1'b1, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL show_cycle%0d: mole=%h req=%b busy=%b hit=%b miss=%b, want mole=%h 0 1 0 0",
                 k, mole_onehot, req, busy, hit_pulse, miss_pulse, m);
      end
      if (k == press_k) btn = press_val;
    end
    tick();
    btn = '0;
    if (hit) begin
      if (exp_score != 4'hF) exp_score++;
    end else begin
      if (exp_miss != 4'hF) exp_miss++;
    end
    total++;
    if ({hit_pulse, miss_pulse, score, miss_count, mole_onehot, busy, req} !==
        {hit, ~hit, exp_score, exp_miss, 8'h00, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL round_result: hit=%b miss=%b score=%0d misses=%0d mole=%h busy=%b req=%b, want %b %b %0d %0d 00 1 0",
               hit_pulse, miss_pulse, score, miss_count, mole_onehot, busy, req,
               hit, ~hit, exp_score, exp_miss);
    end
    if (stray) begin
      sel_done   = 1'b1;
      sel_number = 3'($urandom);
    end
    for (int g = 2; g <= int'(GAP); g++) begin
      tick();
      sel_done = 1'b0;
      total++;
      if ({mole_onehot, hit_pulse, miss_pulse, req, busy} !== {8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
        bad++;
        $display("FAIL gap_cycle%0d: mole=%h hit=%b miss=%b req=%b busy=%b, want 00 0 0 0 1",
                 g, mole_onehot, hit_pulse, miss_pulse, req, busy);
      end
    end
    tick();
    sel_done = 1'b0;
    total++;
    if ({req, busy, game_over, mole_onehot} !== {~last, ~last, last, 8'h00}) begin
      bad++;
      $display("FAIL round_next: req=%b busy=%b over=%b mole=%h, want %b %b %b 00",
               req, busy, game_over, mole_onehot, ~last, ~last, last);
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({req, mole_onehot, score, miss_count, hit_pulse, miss_pulse, busy, game_over, timeout_err} !== 23'h0) begin
      bad++;
      $display("FAIL reset_outputs: req=%b mole=%h score=%0d miss=%0d hp=%b mp=%b busy=%b over=%b terr=%b, want all 0",
               req, mole_onehot, score, miss_count, hit_pulse, miss_pulse, busy, game_over, timeout_err);
    end
  endtask

  task automatic test_stray_idle();
    do_reset();
    sel_done   = 1'b1;
    sel_number = 3'd4;
    btn        = 8'hFF;
    tick();
    sel_done = 1'b0;
    btn      = '0;
    tick();
    total++;
    if ({req, busy, mole_onehot, hit_pulse, miss_pulse} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL stray_idle: req=%b busy=%b mole=%h hp=%b mp=%b, want 0 0 00 0 0",
               req, busy, mole_onehot, hit_pulse, miss_pulse);
    end
  endtask

  task automatic test_spec_game();
    logic [2:0] slots [8];
    bit         hits  [8];
    logic [7:0] m;
    slots = '{3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7};
    hits  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    start_game();
    run_round(2, 3'd5, 2, 8'h20, 1'b0, 1'b0);
    run_round(int'($urandom_range(TMO - 1, 1)), slots[1], 0, 8'h00, 1'b0, 1'b1);
    for (int r = 2; r < 8; r++) begin
      m = 8'b1 << slots[r];
      run_round(int'($urandom_range(TMO - 1, 1)), slots[r],
                hits[r] ? int'($urandom_range(SHOW, 1)) : 0, hits[r] ? m : 8'h00,
                r == 7, 1'($urandom));
    end
    total++;
    if ({game_over, score, miss_count} !== {1'b1, 4'd5, 4'd3}) begin
      bad++;
      $display("FAIL game_total: over=%b score=%0d miss=%0d, want 1 5 3", game_over, score, miss_count);
    end
    for (int i = 0; i < 6; i++) begin
      start = 1'(i % 2);
      tick();
      total++;
      if ({req, busy, game_over, score, miss_count} !== {1'b0, 1'b0, 1'b1, 4'd5, 4'd3}) begin
        bad++;
        $display("FAIL over_hold%0d: req=%b busy=%b over=%b score=%0d miss=%0d, want 0 0 1 5 3",
                 i, req, busy, game_over, score, miss_count);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    start_game();
    for (int i = 1; i <= int'(TMO); i++) begin
      tick();
      total++;
      if ({timeout_err, busy, req, mole_onehot} !== {1'(i == int'(TMO)), 1'(i != int'(TMO)), 1'b0, 8'h00}) begin
        bad++;
        $display("FAIL timeout_cycle%0d: terr=%b busy=%b req=%b mole=%h, want terr=%b",
                 i, timeout_err, busy, req, mole_onehot, i == int'(TMO));
      end
    end
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    total++;
    if ({timeout_err, req, busy} !== {1'b1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL timeout_hold: terr=%b req=%b busy=%b, want 1 0 0", timeout_err, req, busy);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL timeout_rst: terr=%b, want 0", timeout_err);
    end
    rst = 1'b0;
  endtask

  task automatic test_wrong_button();
    do_reset();
    start_game();
    run_round(int'(TMO) - 1, 3'd3, 1, 8'h01, 1'b0, 1'b0);
    run_round(1, 3'd3, 3, 8'h09, 1'b0, 1'b1);
    run_round(3, 3'd6, int'(SHOW), 8'h40, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_show();
    do_reset();
    start_game();
    tick();
    sel_done   = 1'b1;
    sel_number = 3'd2;
    tick();
    sel_done = 1'b0;
    total++;
    if (mole_onehot !== 8'h04) begin
      bad++;
      $display("FAIL mid_show_lit: mole=%h, want 04", mole_onehot);
    end
    tick();
    #2 rst = 1'b1;
    #1;
    total++;
    if ({req, mole_onehot, score, miss_count, hit_pulse, miss_pulse, busy, game_over, timeout_err} !== 23'h0) begin
      bad++;
      $display("FAIL mid_show_rst: req=%b mole=%h score=%0d miss=%0d hp=%b mp=%b busy=%b over=%b terr=%b, want all 0",
               req, mole_onehot, score, miss_count, hit_pulse, miss_pulse, busy, game_over, timeout_err);
    end
    tick();
    rst = 1'b0;
    tick();
    total++;
    if ({busy, req} !== 2'b00) begin
      bad++;
      $display("FAIL post_rst_idle: busy=%b req=%b, want 0 0", busy, req);
    end
  endtask

  task automatic test_random_games();
    logic [2:0] perm [8];
    logic [2:0] tmp;
    logic [7:0] m;
    logic [7:0] val;
    int         j;
    int         pk;
    for (int g = 0; g < 3; g++) begin
      for (int i = 0; i < 8; i++) perm[i] = 3'(i);
      for (int i = 7; i > 0; i--) begin
        j       = int'($urandom_range(i, 0));
        tmp     = perm[i];
        perm[i] = perm[j];
        perm[j] = tmp;
      end
      do_reset();
      start_game();
      for (int r = 0; r < 8; r++) begin
        m  = 8'b1 << perm[r];
        pk = int'($urandom_range(SHOW + 1, 0));
        if ($urandom_range(1, 0) == 1) val = m | 8'($urandom);
        else                           val = 8'($urandom) & ~m;
        run_round(int'($urandom_range(TMO - 1, 1)), perm[r], pk, val, r == 7, 1'($urandom));
      end
      total++;
      if ({game_over, 5'(score + miss_count)} !== {1'b1, 5'd8}) begin
        bad++;
        $display("FAIL rand_game%0d: over=%b score+miss=%0d, want 1 8", g, game_over, score + miss_count);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stray_idle();
    test_spec_game();
    test_timeout();
    test_wrong_button();
    test_reset_mid_show();
    test_random_games();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
